// File: rtl/spi_ram_param.sv
// SPI-slave front end over a single-port RAM, clocked by one system clock; frames commit one edge after the last bit.
// Read data appears on MISO from edge N+2; there is no backpressure, the SPI master paces every frame.
module spi_ram_param #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       op_done,
  output logic [1:0] op_code,
  output logic       abort
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int N     = 2 + PW;
  localparam int CW    = $clog2(N);
  localparam logic [CW-1:0] LAST_RX = CW'(N - 1);
  localparam logic [CW-1:0] LAST_TX = CW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, RECV, COMMIT, RD_LOAD, SHIFT, DONE} state_t;

  state_t              state, state_nx;
  logic [N-1:0]        rx_sr;
  logic [DATA_W-1:0]   tx_sr;
  logic [CW-1:0]       bit_cnt;
  logic [ADDR_W-1:0]   wptr, rptr;
  logic                armed;
  logic                commit, abort_nx;
  logic [1:0]          cmd;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign cmd  = rx_sr[N-1:N-2];
  assign MISO = (state == SHIFT) & tx_sr[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // SS_n high outranks every frame-internal transition, including the commit itself.
  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    abort_nx = 1'b0;
    case (state)
      IDLE:    if (!SS_n && armed) state_nx = RECV;
      RECV: begin
        if (SS_n) begin
          abort_nx = 1'b1;
          state_nx = IDLE;
        end else if (bit_cnt == LAST_RX) begin
          state_nx = COMMIT;
        end
      end
      COMMIT: begin
        if (SS_n) begin
          abort_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          commit   = 1'b1;
          state_nx = (cmd == 2'b11) ? RD_LOAD : DONE;
        end
      end
      RD_LOAD: begin
        if (SS_n) begin
          abort_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (SS_n) begin
          abort_nx = 1'b1;
          state_nx = IDLE;
        end else if (bit_cnt == LAST_TX) begin
          state_nx = DONE;
        end
      end
      DONE:    if (SS_n) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      bit_cnt <= '0;
      wptr    <= '0;
      rptr    <= '0;
      op_code <= 2'b00;
      op_done <= 1'b0;
      abort   <= 1'b0;
    end else begin
      armed   <= armed | SS_n;
      op_done <= commit;
      abort   <= abort_nx;
      case (state)
        IDLE: bit_cnt <= '0;
        RECV: begin
          rx_sr   <= {rx_sr[N-2:0], MOSI};
          bit_cnt <= bit_cnt + CW'(1);
        end
        RD_LOAD: begin
          tx_sr   <= mem[rptr];
          bit_cnt <= '0;
          if (!SS_n && AUTO_INC != 0) rptr <= rptr + ADDR_W'(1);
        end
        SHIFT: begin
          tx_sr   <= tx_sr << 1;
          bit_cnt <= bit_cnt + CW'(1);
        end
        default: ;
      endcase
      if (commit) begin
        op_code <= cmd;
        case (cmd)
          2'b00:   wptr <= rx_sr[ADDR_W-1:0];
          2'b01:   if (AUTO_INC != 0) wptr <= wptr + ADDR_W'(1);
          2'b10:   rptr <= rx_sr[ADDR_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (commit && cmd == 2'b01) mem[wptr] <= rx_sr[DATA_W-1:0];
  end
endmodule
